coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Upstream front-end for the coffee vending FSM; sits between the mechanical coin sensors and the FSM's 3-bit coin input `x`.
- Synchronises, debounces and edge-detects three raw coin lines (1, 2 and 5 units).
- Queues at most one pending coin per denomination and presents each coin to the FSM as a single-cycle code on `x`, separated by idle gaps.
- Rejects coins while the vend is locked.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required before a synchronised line's debounced level changes (legal range 1..255).
- GAP_CYCLES, 2, cycles of x=0 forced after each emitted code (legal range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- coin1_raw  input  1  raw sensor, 1-unit coin; asynchronous, bouncy.
- coin2_raw  input  1  raw sensor, 2-unit coin.
- coin5_raw  input  1  raw sensor, 5-unit coin.
- lock  input  1  high = machine busy/vending; new coins are rejected.
- x  output  3  coin code to the FSM: 0 = none, 1, 2 or 5; registered.
- reject  output  1  one-cycle pulse per coin rejected because lock was high.
- overflow  output  1  sticky; set when a coin is dropped because that denomination's pending flag was already set.

Behaviour:
- Reset: asynchronous, active-high; sync flops, debounced levels, debounce counters, pending flags, FSM (->IDLE), x, reject and overflow all go to 0 immediately. Reset asserted mid-emission aborts the emission; the dropped coin is not re-emitted.
- Synchroniser: two flops per raw line, reset to 0.
- Debounce, per line:
  - Counter counts while the synchronised value differs from the debounced level and resets to 0 whenever they match.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles are ignored.
- Coin event:
  - One-cycle pulse on a debounced 0->1 transition only; falling edges produce nothing.
  - Raw line high from edge N, clean: event at cycle N+2+DEB_CYCLES.
- Event handling, per denomination, evaluated in the event cycle:
  - lock=1: reject pulses high for 1 cycle; pending flag unchanged.
  - lock=0, flag clear: flag set.
  - lock=0, flag set and not being cleared this cycle: overflow set, event dropped.
  - lock=0, flag being cleared by emission this cycle: flag remains set (new coin queued), no overflow.
  - Simultaneous events on several lines are handled independently. If two or more rejected events coincide, reject still pulses for one cycle only.
- Emitter FSM (IDLE, EMIT, GAP):
  - IDLE: if lock=0 and any flag is set, select by priority 5 > 2 > 1, register x = code, clear that flag, go to EMIT. Otherwise x=0.
  - EMIT: x holds the code for exactly 1 cycle; next cycle x=0, gap counter loaded, go to GAP.
  - GAP: x=0 for GAP_CYCLES cycles, then IDLE.
  - Minimum spacing between codes is 2+GAP_CYCLES cycles.
  - lock rising during EMIT or GAP does not truncate the current code or gap. lock high in IDLE holds the pending flags without emitting.
  - Latency from event to x valid (idle machine, lock=0): 2 cycles (flag set, then x registered).
- overflow clears only on reset.

Optional Feature:
- Macro: COIN_TOTAL_EN.
- When defined:
  - Adds output `credit` [7:0]: running sum of emitted codes, added in the cycle x is loaded.
  - Saturates at 255.
  - Clears on reset or on the cycle lock falls 1->0 (end of vend).
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Clean coin2_raw high for 10 cycles, lock=0, defaults -> x=2 for exactly one cycle at edge N+8 (event N+6, flag N+7, x N+8), then x=0; reject=0, overflow=0.
- coin1_raw glitch high 3 cycles (DEB_CYCLES=4) -> no event, x stays 0 throughout.
- coin1, coin2, coin5 debounced rising in the same cycle -> x sequence 5, then 2 four cycles later, then 1 four cycles after that; each value for one cycle.
- Two clean coin1 insertions with lock=1 -> two reject pulses, x never nonzero; drop lock -> still no emission.
- Three coin5 events 3 cycles apart, lock=0 -> x=5 twice (first emitted, second queued in its flag), third dropped; overflow=1 and stays 1 until reset.
- Assert reset during the GAP after an x=2 with a coin1 pending -> all outputs 0 asynchronously; after reset release, no x=1 emitted.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises, debounces and edge-detects three coin sensors, then feeds
// single-cycle coin codes to the vending FSM. Define COIN_TOTAL_EN to add the `credit` total.
module coin_acceptor #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin1_raw,
  input  logic       coin2_raw,
  input  logic       coin5_raw,
  input  logic       lock,
  output logic [2:0] x,
  output logic       reject,
  output logic       overflow
`ifdef COIN_TOTAL_EN
  ,
  output logic [7:0] credit
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [7:0] DEB_MAX  = 8'(DEB_CYCLES);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  // Line index 0 = 1-unit, 1 = 2-unit, 2 = 5-unit coin.
  logic [2:0]      raw_in;
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      deb_q, deb_d;
  logic [2:0][7:0] cnt_q, cnt_d;
  logic [2:0]      event_q, event_d;
  logic [2:0]      flag_q, flag_d;
  logic [2:0]      clear;
  logic [2:0]      accept;
  logic [1:0]      state_q, state_d;
  logic [3:0]      gap_q, gap_d;
  logic [2:0]      x_q, x_d;
  logic            reject_q, reject_d;
  logic            overflow_q, overflow_d;

  assign raw_in = {coin5_raw, coin2_raw, coin1_raw};

  // The debounced level flips only after the synchronised value has disagreed for DEB_CYCLES+1 edges.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
    event_d = deb_d & ~deb_q;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    x_d     = 3'd0;
    clear   = 3'b000;
    case (state_q)
      IDLE: begin
        if (!lock && |flag_q) begin
          if (flag_q[2]) begin
            x_d   = 3'd5;
            clear = 3'b100;
          end else if (flag_q[1]) begin
            x_d   = 3'd2;
            clear = 3'b010;
          end else begin
            x_d   = 3'd1;
            clear = 3'b001;
          end
          state_d = EMIT;
        end
      end
      EMIT: begin
        gap_d   = GAP_LOAD;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A coin arriving while its own flag is being emitted simply re-queues instead of overflowing.
  always_comb begin
    accept     = event_q & {3{~lock}};
    flag_d     = (flag_q & ~clear) | accept;
    overflow_d = overflow_q | (|(accept & flag_q & ~clear));
    reject_d   = lock & (|event_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      deb_q      <= 3'b000;
      cnt_q      <= '0;
      event_q    <= 3'b000;
      flag_q     <= 3'b000;
      state_q    <= IDLE;
      gap_q      <= 4'd0;
      x_q        <= 3'd0;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      event_q    <= event_d;
      flag_q     <= flag_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      x_q        <= x_d;
      reject_q   <= reject_d;
      overflow_q <= overflow_d;
    end
  end

  assign x        = x_q;
  assign reject   = reject_q;
  assign overflow = overflow_q;

`ifdef COIN_TOTAL_EN
  logic       lock_q;
  logic [7:0] credit_q, credit_d;
  logic [8:0] credit_sum;

  // End of vend restarts the total; a coin loaded in that same cycle still counts.
  always_comb begin
    credit_sum = {1'b0, (lock_q && !lock) ? 8'd0 : credit_q} + {6'd0, x_d};
    credit_d   = credit_sum[8] ? 8'hFF : credit_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q   <= 1'b0;
      credit_q <= 8'd0;
    end else begin
      lock_q   <= lock;
      credit_q <= credit_d;
    end
  end

  assign credit = credit_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed and randomized stimulus for coin_acceptor, checked every cycle
// against a time-based reference model of the coin front-end.
module tb_coin_acceptor;

  localparam int DEB = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin1_raw, coin2_raw, coin5_raw;
  logic       lock;
  logic [2:0] x;
  logic       reject;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int edgeNum = 0;
  int rejCount = 0;
  int startEdge;
  logic [2:0] xSeq[$];
  int xEdge[$];

  // Reference model: debounce as a sliding window of synchronised samples, emitter as a "free again at" edge.
  bit [2:0]   mFlag;
  bit [2:0]   mDeb;
  bit [2:0]   mPipe1, mPipe2;
  bit [2:0]   mEvPrev;
  bit [DEB:0] mWin[3];
  int         mNextFree;
  logic [2:0] mX;
  logic       mRej;
  logic       mOvf;

  coin_acceptor #(
    .DEB_CYCLES(DEB),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .coin1_raw(coin1_raw),
    .coin2_raw(coin2_raw),
    .coin5_raw(coin5_raw),
    .lock     (lock),
    .x        (x),
    .reject   (reject),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] codeOf(input int i);
    return (i == 2) ? 3'd5 : ((i == 1) ? 3'd2 : 3'd1);
  endfunction

  function automatic int seqAt(input int i);
    return (i < xSeq.size()) ? int'(xSeq[i]) : -1;
  endfunction

  function automatic int edgeAt(input int i);
    return (i < xEdge.size()) ? xEdge[i] : -1;
  endfunction

  task automatic modelReset();
    mFlag     = 3'b000;
    mDeb      = 3'b000;
    mPipe1    = 3'b000;
    mPipe2    = 3'b000;
    mEvPrev   = 3'b000;
    for (int i = 0; i < 3; i++) mWin[i] = '0;
    mNextFree = 0;
    mX        = 3'd0;
    mRej      = 1'b0;
    mOvf      = 1'b0;
  endtask

  // One rising edge of the model, using the raw/lock values sampled at that edge.
  task automatic modelStep(input logic [2:0] raw, input logic lk);
    bit [2:0] clr;
    bit [2:0] evNew;
    clr   = 3'b000;
    evNew = 3'b000;
    mX    = 3'd0;
    mRej  = 1'b0;
    if (edgeNum >= mNextFree && !lk && mFlag != 3'b000) begin
      if (mFlag[2]) clr = 3'b100;
      else if (mFlag[1]) clr = 3'b010;
      else clr = 3'b001;
      for (int i = 0; i < 3; i++) if (clr[i]) mX = codeOf(i);
      mNextFree = edgeNum + 2 + GAP;
    end
    for (int i = 0; i < 3; i++) begin
      if (mEvPrev[i]) begin
        if (lk) mRej = 1'b1;
        else if (mFlag[i] && !clr[i]) mOvf = 1'b1;
        else mFlag[i] = 1'b1;
      end else begin
        mFlag[i] = mFlag[i] & ~clr[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      mWin[i] = {mWin[i][DEB-1:0], mPipe2[i]};
      if (mWin[i] == {(DEB+1){~mDeb[i]}}) begin
        mDeb[i]  = ~mDeb[i];
        evNew[i] = mDeb[i];
      end
    end
    mPipe2  = mPipe1;
    mPipe1  = raw;
    mEvPrev = evNew;
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (x === mX) else begin
      errors++;
      $error("[TB] FAIL %s_x edge=%0d observed=%0d expected=%0d", tag, edgeNum, x, mX);
    end
    checks++;
    assert (reject === mRej) else begin
      errors++;
      $error("[TB] FAIL %s_reject edge=%0d observed=%b expected=%b", tag, edgeNum, reject, mRej);
    end
    checks++;
    assert (overflow === mOvf) else begin
      errors++;
      $error("[TB] FAIL %s_overflow edge=%0d observed=%b expected=%b", tag, edgeNum, overflow, mOvf);
    end
    if (x !== 3'd0) begin
      xSeq.push_back(x);
      xEdge.push_back(edgeNum);
    end
    if (reject === 1'b1) rejCount++;
  endtask

  // Drives inputs at the falling edge, then models and checks just after each rising edge.
  task automatic applyStimulus(input logic [2:0] raw, input logic lk, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      coin1_raw = raw[0];
      coin2_raw = raw[1];
      coin5_raw = raw[2];
      lock      = lk;
      @(posedge clk);
      #1;
      edgeNum++;
      if (reset) modelReset();
      else modelStep(raw, lk);
      checkOutput("cycle");
    end
  endtask

  task automatic clearLog();
    xSeq.delete();
    xEdge.delete();
    rejCount = 0;
  endtask

  initial begin
    reset     = 1'b1;
    coin1_raw = 1'b0;
    coin2_raw = 1'b0;
    coin5_raw = 1'b0;
    lock      = 1'b0;
    modelReset();
    applyStimulus(3'b000, 1'b0, 3);
    reset = 1'b0;
    applyStimulus(3'b000, 1'b0, 5);

    $display("[TB] clean coin2 insertion");
    clearLog();
    startEdge = edgeNum + 1;
    applyStimulus(3'b010, 1'b0, 10);
    applyStimulus(3'b000, 1'b0, 20);
    checkValue("coin2_count", xSeq.size(), 1);
    checkValue("coin2_code", seqAt(0), 2);
    checkValue("coin2_latency", edgeAt(0) - startEdge, 8);

    $display("[TB] short glitch on coin1");
    clearLog();
    applyStimulus(3'b001, 1'b0, 3);
    applyStimulus(3'b000, 1'b0, 20);
    checkValue("glitch_count", xSeq.size(), 0);

    $display("[TB] three denominations together");
    clearLog();
    applyStimulus(3'b111, 1'b0, 10);
    applyStimulus(3'b000, 1'b0, 25);
    checkValue("prio_count", xSeq.size(), 3);
    checkValue("prio_first", seqAt(0), 5);
    checkValue("prio_second", seqAt(1), 2);
    checkValue("prio_third", seqAt(2), 1);
    checkValue("prio_gap1", edgeAt(1) - edgeAt(0), 4);
    checkValue("prio_gap2", edgeAt(2) - edgeAt(1), 4);

    $display("[TB] coins rejected while locked");
    clearLog();
    applyStimulus(3'b001, 1'b1, 10);
    applyStimulus(3'b000, 1'b1, 10);
    applyStimulus(3'b001, 1'b1, 10);
    applyStimulus(3'b000, 1'b1, 10);
    checkValue("lock_rejects", rejCount, 2);
    applyStimulus(3'b000, 1'b0, 20);
    checkValue("lock_no_emit", xSeq.size(), 0);

    $display("[TB] overflow on a held coin1 flag");
    clearLog();
    applyStimulus(3'b011, 1'b0, 8);
    applyStimulus(3'b011, 1'b1, 2);
    applyStimulus(3'b000, 1'b1, 8);
    applyStimulus(3'b001, 1'b1, 7);
    applyStimulus(3'b001, 1'b0, 1);
    checkValue("ovf_set", overflow, 1);
    applyStimulus(3'b001, 1'b0, 3);
    applyStimulus(3'b000, 1'b0, 17);
    checkValue("ovf_count", xSeq.size(), 2);
    checkValue("ovf_first", seqAt(0), 2);
    checkValue("ovf_second", seqAt(1), 1);
    checkValue("ovf_sticky", overflow, 1);

    $display("[TB] reset during gap with coin1 pending");
    clearLog();
    applyStimulus(3'b011, 1'b0, 9);
    applyStimulus(3'b000, 1'b0, 1);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    checkValue("async_overflow", overflow, 0);
    applyStimulus(3'b000, 1'b0, 2);
    reset = 1'b0;
    applyStimulus(3'b000, 1'b0, 20);
    checkValue("reset_count", xSeq.size(), 1);
    checkValue("reset_code", seqAt(0), 2);

    $display("[TB] randomized coins and lock");
    for (int s = 0; s < 90; s++) begin
      logic [2:0] rawR;
      logic       lockR;
      rawR  = 3'($urandom_range(0, 7));
      lockR = ($urandom_range(0, 3) == 0);
      applyStimulus(rawR, lockR, $urandom_range(1, 12));
    end
    applyStimulus(3'b000, 1'b0, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
